boundary_scan_driver: RTL and testbench

Initiator side of the boundary-scan chain interface: it generates scan_tdi and scan_control[3:0] for a downstream boundary_scan_chain and collects its scan_tdo.
- Accepts one command at a time over a valid/ready handshake.
- Sequences capture, serial shift and update phases cycle-exactly.
- Returns the shifted-out chain contents on a valid/ready response channel.
- Sits between the test-access controller logic and one boundary_scan_chain instance, all on tck.

---
 rtl/boundary_scan_pkg.sv | 37 +++
 rtl/boundary_scan_driver.sv | 113 +++++++++++
 tb/tb_boundary_scan_driver.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/boundary_scan_pkg.sv
// Shared encodings for the boundary-scan initiator: command ops, control bit
// positions on scan_control, and the driver state machine states.
package boundary_scan_pkg;

    typedef enum logic [1:0] {
        OP_SHIFT     = 2'd0,
        OP_CAP_SHIFT = 2'd1,
        OP_SHIFT_UPD = 2'd2,
        OP_FULL      = 2'd3
    } op_e;

    localparam int CTRL_SHIFT   = 0;
    localparam int CTRL_UPDATE  = 1;
    localparam int CTRL_CAPTURE = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        SHIFT   = 3'd2,
        UPDATE  = 3'd3,
        DONE    = 3'd4
    } state_e;

    // Chain control word presented while the driver sits in a given state.
    function automatic logic [3:0] ctrl_for(input state_e s);
        logic [3:0] c;
        c = 4'b0000;
        case (s)
            CAPTURE: c[CTRL_CAPTURE] = 1'b1;
            SHIFT:   c[CTRL_SHIFT]   = 1'b1;
            UPDATE:  c[CTRL_UPDATE]  = 1'b1;
            default: c = 4'b0000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/boundary_scan_driver.sv
// Boundary-scan initiator: runs capture / CHAIN_LEN-bit shift / update on one chain per command.
// Latency: acceptance to rsp_valid = CHAIN_LEN+1 cycles, +1 each for capture and update; rsp held until rsp_ready.
module boundary_scan_driver
    import boundary_scan_pkg::*;
#(
    parameter int CHAIN_LEN = 8
) (
    input  logic                 tck,
    input  logic                 trst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [CHAIN_LEN-1:0] cmd_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [CHAIN_LEN-1:0] rsp_data,
    output logic                 busy,
    output logic                 scan_tdi,
    input  logic                 scan_tdo,
    output logic [3:0]           scan_control
);

    localparam int CW = $clog2(CHAIN_LEN + 1);

    state_e               state_q, state_d;
    logic                 upd_q, upd_d;
    logic [CHAIN_LEN-1:0] wr_sh_q, wr_sh_d;
    logic [CHAIN_LEN-1:0] rd_sh_q, rd_sh_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] rsp_data_q, rsp_data_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [3:0]           ctrl_q, ctrl_d;
    logic                 tdi_q, tdi_d;

    always_comb begin
        state_d     = state_q;
        upd_d       = upd_q;
        wr_sh_d     = wr_sh_q;
        rd_sh_d     = rd_sh_q;
        cnt_d       = cnt_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    upd_d   = cmd_op[1];
                    wr_sh_d = cmd_data;
                    state_d = cmd_op[0] ? CAPTURE : SHIFT;
                end
            end
            CAPTURE: state_d = SHIFT;
            SHIFT: begin
                // tdo is the chain MSB before this edge's shift.
                rd_sh_d = {rd_sh_q[CHAIN_LEN-2:0], scan_tdo};
                wr_sh_d = wr_sh_q << 1;
                if (cnt_q == CW'(CHAIN_LEN - 1)) begin
                    cnt_d      = '0;
                    rsp_data_d = rd_sh_d;
                    state_d    = upd_q ? UPDATE : DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            UPDATE: state_d = DONE;
            DONE: begin
                // rsp_valid is registered, so it rises one cycle after entering DONE;
                // a ready seen before that is ignored.
                rsp_valid_d = 1'b1;
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ctrl_d = ctrl_for(state_d);
        tdi_d  = (state_d == SHIFT) ? wr_sh_d[CHAIN_LEN-1] : 1'b0;
    end

    always_ff @(posedge tck) begin
        if (!trst_n) begin
            state_q     <= IDLE;
            upd_q       <= 1'b0;
            wr_sh_q     <= '0;
            rd_sh_q     <= '0;
            cnt_q       <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            ctrl_q      <= 4'b0000;
            tdi_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            upd_q       <= upd_d;
            wr_sh_q     <= wr_sh_d;
            rd_sh_q     <= rd_sh_d;
            cnt_q       <= cnt_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            ctrl_q      <= ctrl_d;
            tdi_q       <= tdi_d;
        end
    end

    assign cmd_ready    = trst_n && (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign scan_control = ctrl_q;
    assign scan_tdi     = tdi_q;

endmodule

// File: tb/tb_boundary_scan_driver.sv
// Bench for boundary_scan_driver with a behavioural 8-cell chain as its load.
module tb_boundary_scan_driver;
    import boundary_scan_pkg::*;

    localparam int N = 8;

    logic         tck = 1'b0;
    logic         trst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [N-1:0] cmd_data;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_data;
    logic         busy;
    logic         scan_tdi;
    logic         scan_tdo;
    logic [3:0]   scan_control;

    always #5 tck = ~tck;

    boundary_scan_driver #(.CHAIN_LEN(N)) dut (
        .tck(tck), .trst_n(trst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .scan_tdi(scan_tdi), .scan_tdo(scan_tdo), .scan_control(scan_control)
    );

    // Chain load: capture has priority over shift; update copies the shift stage out.
    logic [N-1:0] ch_sh   = '0;
    logic [N-1:0] ch_dout = '0;
    logic [N-1:0] ch_din  = '0;
    always @(posedge tck) begin
        if (scan_control[CTRL_CAPTURE])    ch_sh <= ch_din;
        else if (scan_control[CTRL_SHIFT]) ch_sh <= {ch_sh[N-2:0], scan_tdi};
        if (scan_control[CTRL_UPDATE])     ch_dout <= ch_sh;
    end
    assign scan_tdo = ch_sh[N-1];

    typedef struct {
        logic [N-1:0] rsp;
        logic [N-1:0] dout;
        int           lat;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge tck) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    int acc_edge = 0;
    int hs_edge  = 0;
    int shcnt    = 0;
    bit prev_v   = 0;
    bit chk_gap  = 0;
    bit live     = 0;

    always @(negedge tck) begin
        if (!trst_n) begin
            prev_v = 0;
            shcnt  = 0;
        end else if (live) begin
            chk("ctrl_reserved", {31'd0, scan_control[3]}, 0);
            chk("ctrl_onehot0", {31'd0, $onehot0(scan_control[2:0])}, 1);
            chk("busy_vs_ready", {31'd0, busy}, {31'd0, !cmd_ready});
            if (scan_control[CTRL_SHIFT]) shcnt++;
            if (cmd_valid && cmd_ready) begin
                acc_edge = cyc + 1;
                if (chk_gap) begin
                    chk("accept_gap", acc_edge - hs_edge, 1);
                    chk_gap = 0;
                end
            end
            if (rsp_valid && !prev_v) begin
                if (sb.size() == 0) chk("spurious_rsp", 1, 0);
                else begin
                    chk("latency", cyc - acc_edge, sb[0].lat);
                    chk("shift_cycles", shcnt, N);
                end
                shcnt = 0;
            end
            if (rsp_valid && rsp_ready && sb.size() > 0) begin
                chk("rsp_data", rsp_data, sb[0].rsp);
                chk("chain_data_out", ch_dout, sb[0].dout);
                void'(sb.pop_front());
                hs_edge = cyc + 1;
            end
            prev_v = rsp_valid;
        end
    end

    task automatic send(input logic [1:0] op, input logic [N-1:0] d, input logic [N-1:0] er,
                        input logic [N-1:0] ed, input int lat, input bit expect_rsp);
        bit accepted;
        accepted = 0;
        if (expect_rsp) sb.push_back('{er, ed, lat});
        cmd_op    = op;
        cmd_data  = d;
        cmd_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge tck);
            if (cmd_ready) begin
                accepted = 1;
                break;
            end
        end
        if (!accepted) chk("accept_timeout", 0, 1);
        @(posedge tck);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge tck);
            if (sb.size() == 0) begin
                done = 1;
                break;
            end
        end
        if (!done) chk("rsp_timeout", 0, 1);
        @(posedge tck);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        trst_n    = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 2'd3;
        cmd_data  = 8'h5A;
        rsp_ready = 1'b1;

        // Reset held with a pending command.
        repeat (3) @(posedge tck);
        @(negedge tck);
        chk("rst_ctrl", {28'd0, scan_control}, 0);
        chk("rst_tdi", {31'd0, scan_tdi}, 0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 0);
        @(posedge tck);
        #1 trst_n = 1'b1;
        cmd_valid = 1'b0;
        live      = 1;
        @(negedge tck);
        chk("rel_cmd_ready", {31'd0, cmd_ready}, 1);
        chk("rel_busy", {31'd0, busy}, 0);
        @(posedge tck);
        #1;

        // Full op: capture A5, load 3C.
        ch_din = 8'hA5;
        send(OP_FULL, 8'h3C, 8'hA5, 8'h3C, 11, 1);
        wait_idle();

        // Shift only: read back 3C, load FF, data_out untouched.
        send(OP_SHIFT, 8'hFF, 8'h3C, 8'h3C, 9, 1);
        wait_idle();
        chk("chain_holds_ff", ch_sh, 8'hFF);

        // Backpressure with a second command queued behind it.
        rsp_ready = 1'b0;
        send(OP_SHIFT_UPD, 8'h81, 8'hFF, 8'h81, 10, 1);
        fork
            begin
                chk_gap = 1;
                send(OP_SHIFT, 8'h42, 8'h81, 8'h81, 9, 1);
            end
            begin
                bit seen;
                seen = 0;
                for (int i = 0; i < 100; i++) begin
                    @(negedge tck);
                    if (rsp_valid) begin
                        seen = 1;
                        break;
                    end
                end
                if (!seen) chk("bp_rsp_timeout", 0, 1);
                repeat (5) begin
                    @(negedge tck);
                    chk("bp_valid_held", {31'd0, rsp_valid}, 1);
                    chk("bp_data_held", rsp_data, 8'hFF);
                    chk("bp_cmd_ready", {31'd0, cmd_ready}, 0);
                end
                @(posedge tck);
                #1 rsp_ready = 1'b1;
            end
        join
        wait_idle();
        chk("chain_holds_42", ch_sh, 8'h42);

        // Reset after the 4th shift edge of a full op.
        ch_din = 8'h5A;
        send(OP_FULL, 8'h99, 8'h00, 8'h00, 0, 0);
        repeat (5) @(posedge tck);
        #1 trst_n = 1'b0;
        @(posedge tck);
        #1 trst_n = 1'b1;
        @(negedge tck);
        chk("midrst_ctrl", {28'd0, scan_control}, 0);
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("midrst_busy", {31'd0, busy}, 0);
        repeat (3) begin
            @(negedge tck);
            chk("midrst_no_rsp", {31'd0, rsp_valid}, 0);
        end
        @(posedge tck);
        #1;

        // Commands after the abort complete normally.
        ch_din = 8'h77;
        send(OP_CAP_SHIFT, 8'h00, 8'h77, 8'h81, 10, 1);
        wait_idle();
        ch_din = 8'h11;
        send(OP_FULL, 8'hC3, 8'h11, 8'hC3, 11, 1);
        wait_idle();

        repeat (3) @(posedge tck);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
